// File: rtl/reg_dump_unit_pkg.sv
// Shared debug definitions for the register-dump path: FSM states, sizes
// and the byte-lane selector used to serialise a captured register.
package reg_dump_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_e;

  localparam int BYTES_PER_REG = 4;
  localparam int DBG_ADDR_W    = 5;

  // Byte 'idx' of the serial order; MSB-first order mirrors the lane index.
  function automatic logic [7:0] sel_byte(input logic [31:0] word,
                                          input logic [1:0]  idx,
                                          input logic        lsb_first);
    logic [1:0] lane;
    lane = lsb_first ? idx : (2'd3 - idx);
    case (lane)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      2'd3:    sel_byte = word[31:24];
      default: sel_byte = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/reg_dump_unit_if.sv
// Debug read port towards the register file plus the valid/ready byte
// stream towards UART TX; names are seen from the dump unit's side.
interface reg_dump_unit_if;
  import reg_dump_unit_pkg::*;

  logic [DBG_ADDR_W-1:0] rs_dbg_addr_o;
  logic [31:0]           rs_dbg_data_i;
  logic [7:0]            tx_data_o;
  logic                  tx_valid_o;
  logic                  tx_ready_i;

  modport master (
    output rs_dbg_addr_o, tx_data_o, tx_valid_o,
    input  rs_dbg_data_i, tx_ready_i
  );

  modport slave (
    input  rs_dbg_addr_o, tx_data_o, tx_valid_o,
    output rs_dbg_data_i, tx_ready_i
  );

endinterface

// File: rtl/reg_dump_unit.sv
// Walks x0..x(NUM_REGS-1) over the register-file debug port and streams
// each captured word as four bytes onto the UART TX handshake.
module reg_dump_unit
  import reg_dump_unit_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  reg_dump_unit_if.master  dbg,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [DBG_ADDR_W-1:0] LAST_IDX = DBG_ADDR_W'(NUM_REGS - 1);

  dump_state_e           r_state;
  logic [DBG_ADDR_W-1:0] r_reg_idx;
  logic [1:0]            r_byte_cnt;
  logic [31:0]           r_shift;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_busy;
  logic                  r_done;

  dump_state_e           w_state_nxt;
  logic [DBG_ADDR_W-1:0] w_reg_idx_nxt;
  logic [1:0]            w_byte_cnt_nxt;
  logic [31:0]           w_shift_nxt;
  logic [7:0]            w_tx_data_nxt;
  logic                  w_accept;

  // r_tx_valid is high exactly while in SEND, so it doubles as the state qualifier.
  assign w_accept = r_tx_valid & dbg.tx_ready_i;

  // Next-state and next-datapath decode; outputs are registered from these.
  always_comb begin
    w_state_nxt    = r_state;
    w_reg_idx_nxt  = r_reg_idx;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shift_nxt    = r_shift;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_reg_idx_nxt = {DBG_ADDR_W{1'b0}};
          w_state_nxt   = LATCH;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      LATCH: begin
        w_shift_nxt    = dbg.rs_dbg_data_i;
        w_byte_cnt_nxt = 2'd0;
        w_state_nxt    = SEND;
      end
      SEND: begin
        if (!w_accept) begin
          w_state_nxt = SEND;
        end else if (r_byte_cnt != 2'd3) begin
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
        end else if (r_reg_idx != LAST_IDX) begin
          w_reg_idx_nxt = r_reg_idx + {{(DBG_ADDR_W-1){1'b0}}, 1'b1};
          w_state_nxt   = LATCH;
        end else begin
          w_state_nxt   = DONE;
        end
      end
      DONE: begin
        w_reg_idx_nxt = {DBG_ADDR_W{1'b0}};
        w_state_nxt   = IDLE;
      end
      default: begin
        w_reg_idx_nxt = {DBG_ADDR_W{1'b0}};
        w_state_nxt   = IDLE;
      end
    endcase

    // Abort wins over every active-state transition; a byte accepted now still counts.
    if (abort_i && (r_state != IDLE)) begin
      w_state_nxt   = IDLE;
      w_reg_idx_nxt = {DBG_ADDR_W{1'b0}};
    end else begin
      w_state_nxt   = w_state_nxt;
    end

    if (w_state_nxt == SEND) begin
      w_tx_data_nxt = sel_byte(w_shift_nxt, w_byte_cnt_nxt, LSB_FIRST);
    end else begin
      w_tx_data_nxt = r_tx_data;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_reg_idx  <= {DBG_ADDR_W{1'b0}};
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_reg_idx  <= w_reg_idx_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= (w_state_nxt == SEND);
      r_busy     <= (w_state_nxt == LATCH) || (w_state_nxt == SEND);
      r_done     <= (w_state_nxt == DONE);
    end
  end

  assign dbg.rs_dbg_addr_o = r_reg_idx;
  assign dbg.tx_data_o     = r_tx_data;
  assign dbg.tx_valid_o    = r_tx_valid;
  assign busy_o            = r_busy;
  assign done_o            = r_done;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: two instances (LSB-first and MSB-first)
// share stimulus and a modelled register file; streams are checked bytewise.
module tb_reg_dump_unit;

  logic clk;
  logic rst_n;
  logic start_i;
  logic abort_i;
  logic ready;
  logic busy_l, done_l, busy_m, done_m;

  logic [31:0] regs [32];
  logic [7:0]  q_l [$];
  logic [7:0]  q_m [$];

  int n_checks;
  int n_fail;

  reg_dump_unit_if if_l ();
  reg_dump_unit_if if_m ();

  assign if_l.rs_dbg_data_i = regs[if_l.rs_dbg_addr_o];
  assign if_m.rs_dbg_data_i = regs[if_m.rs_dbg_addr_o];
  assign if_l.tx_ready_i    = ready;
  assign if_m.tx_ready_i    = ready;

  reg_dump_unit #(.NUM_REGS(32), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .dbg(if_l), .busy_o(busy_l), .done_o(done_l)
  );

  reg_dump_unit #(.NUM_REGS(32), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .dbg(if_m), .busy_o(busy_m), .done_o(done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input int b, input bit lsb);
    logic [31:0] v;
    v = regs[k];
    return lsb ? v[8*b +: 8] : v[31-8*b -: 8];
  endfunction

  // One dump; optional mid-dump restart pulse, abort or reset at a given byte count.
  task automatic run_dump(input string tag, input int ready_pct, input int restart_at,
                          input int abort_at, input int rst_at);
    int done_cnt;
    int done_cyc;
    int abort_cyc;
    bit finished;
    bit restarted;
    bit stall;
    logic [7:0] prev;
    q_l = {};
    q_m = {};
    done_cnt = 0; done_cyc = -1; abort_cyc = -1;
    finished = 1'b0; restarted = 1'b0; stall = 1'b0; prev = 8'd0;
    @(negedge clk);
    start_i = 1'b1;
    ready   = 1'b1;
    for (int c = 1; c <= 3000 && !finished; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      if (ready_pct >= 100) ready = 1'b1;
      else ready = ($urandom_range(0, 99) < ready_pct);
      if (c == 1) begin
        check({tag, "_busy_c1"}, {31'd0, busy_l}, 32'd1);
        check({tag, "_valid_c1"}, {31'd0, if_l.tx_valid_o}, 32'd0);
      end
      if (stall) begin
        check({tag, "_stall_valid"}, {31'd0, if_l.tx_valid_o}, 32'd1);
        check({tag, "_stall_data"}, {24'd0, if_l.tx_data_o}, {24'd0, prev});
      end
      if (abort_cyc >= 0 && c == abort_cyc + 1) begin
        check({tag, "_abort_valid"}, {31'd0, if_l.tx_valid_o}, 32'd0);
        check({tag, "_abort_busy"}, {31'd0, busy_l}, 32'd0);
      end
      if (abort_at >= 0 && abort_cyc < 0 && q_l.size() == abort_at && if_l.tx_valid_o) begin
        abort_i   = 1'b1;
        ready     = 1'b1;
        abort_cyc = c;
      end
      if (restart_at >= 0 && !restarted && q_l.size() == restart_at) begin
        start_i   = 1'b1;
        restarted = 1'b1;
      end
      if (rst_at >= 0 && q_l.size() == rst_at && if_l.tx_valid_o) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, {31'd0, if_l.tx_valid_o}, 32'd0);
        check({tag, "_rst_data"}, {24'd0, if_l.tx_data_o}, 32'd0);
        check({tag, "_rst_addr"}, {27'd0, if_l.rs_dbg_addr_o}, 32'd0);
        check({tag, "_rst_busy"}, {31'd0, busy_l}, 32'd0);
        check({tag, "_rst_valid_m"}, {31'd0, if_m.tx_valid_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        finished = 1'b1;
      end else begin
        if (if_l.tx_valid_o && ready) q_l.push_back(if_l.tx_data_o);
        if (if_m.tx_valid_o && ready) q_m.push_back(if_m.tx_data_o);
        stall = if_l.tx_valid_o && !ready;
        prev  = if_l.tx_data_o;
        if (done_l) begin
          done_cnt++;
          done_cyc = c;
        end
        if (done_cyc > 0 && c == done_cyc + 1) begin
          check({tag, "_busy_after"}, {31'd0, busy_l}, 32'd0);
          check({tag, "_done_width"}, {31'd0, done_l}, 32'd0);
          finished = 1'b1;
        end
        if (abort_cyc >= 0 && c == abort_cyc + 12) finished = 1'b1;
      end
    end
    if (!finished) check({tag, "_timeout"}, 32'd0, 32'd1);
    if (rst_at < 0 && abort_at >= 0) begin
      check({tag, "_abort_len"}, q_l.size(), abort_at + 1);
      check({tag, "_abort_done"}, done_cnt, 32'd0);
      for (int i = 0; i < q_l.size() && i <= abort_at; i++)
        check({tag, "_abort_byte"}, {24'd0, q_l[i]}, {24'd0, exp_byte(i / 4, i % 4, 1'b1)});
    end else if (rst_at < 0) begin
      check({tag, "_len_l"}, q_l.size(), 32'd128);
      check({tag, "_len_m"}, q_m.size(), 32'd128);
      check({tag, "_done_cnt"}, done_cnt, 32'd1);
      if (ready_pct >= 100) check({tag, "_done_cyc"}, done_cyc, 32'd161);
      for (int i = 0; i < q_l.size(); i++)
        check({tag, "_byte_l"}, {24'd0, q_l[i]}, {24'd0, exp_byte(i / 4, i % 4, 1'b1)});
      for (int i = 0; i < q_m.size(); i++)
        check({tag, "_byte_m"}, {24'd0, q_m[i]}, {24'd0, exp_byte(i / 4, i % 4, 1'b0)});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    ready    = 1'b1;
    regs[0]  = 32'h0000_0000;
    regs[1]  = 32'h1122_3344;
    regs[31] = 32'hDEAD_BEEF;
    for (int k = 2; k < 31; k++)
      regs[k] = {8'(k), 8'(k + 32'h40), 8'(k + 32'h80), 8'(k + 32'hC0)};

    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, if_l.tx_valid_o}, 32'd0);
    check("rst_data", {24'd0, if_l.tx_data_o}, 32'd0);
    check("rst_addr", {27'd0, if_l.rs_dbg_addr_o}, 32'd0);
    check("rst_busy", {31'd0, busy_l}, 32'd0);
    check("rst_done", {31'd0, done_l}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy_l}, 32'd0);

    run_dump("full", 100, -1, -1, -1);
    check("b0", {24'd0, q_l[0]}, 32'h00);
    check("b3", {24'd0, q_l[3]}, 32'h00);
    check("b4", {24'd0, q_l[4]}, 32'h44);
    check("b5", {24'd0, q_l[5]}, 32'h33);
    check("b6", {24'd0, q_l[6]}, 32'h22);
    check("b7", {24'd0, q_l[7]}, 32'h11);
    check("b124", {24'd0, q_l[124]}, 32'hEF);
    check("b125", {24'd0, q_l[125]}, 32'hBE);
    check("b126", {24'd0, q_l[126]}, 32'hAD);
    check("b127", {24'd0, q_l[127]}, 32'hDE);
    check("m4", {24'd0, q_m[4]}, 32'h11);
    check("m5", {24'd0, q_m[5]}, 32'h22);
    check("m6", {24'd0, q_m[6]}, 32'h33);
    check("m7", {24'd0, q_m[7]}, 32'h44);
    check("m124", {24'd0, q_m[124]}, 32'hDE);

    run_dump("bp", 30, -1, -1, -1);
    run_dump("restart", 100, 40, -1, -1);
    run_dump("abort", 100, -1, 50, -1);
    run_dump("after_abort", 100, -1, -1, -1);
    run_dump("rstmid", 100, -1, -1, 20);
    run_dump("after_rst", 100, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Debug-side consumer of the register file's debug read port.
- On a start pulse, walks x0..x(NUM_REGS-1) through the debug address/data port and captures each 32-bit value.
- Serialises each value as 4 bytes onto a valid/ready byte stream that feeds the UART TX path.
- Used by the debug controller to dump architectural state while the core is halted.

Parameters:
- NUM_REGS, 32, number of registers dumped, starting at index 0; legal range 1..32.
- LSB_FIRST, 1, byte order per register: 1 = bits [7:0] first, 0 = bits [31:24] first.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  dump request; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE, no done pulse.
- rs_dbg_addr_o  out  5  debug read address to the register file.
- rs_dbg_data_i  in  32  debug read data (combinational from rs_dbg_addr_o).
- tx_data_o  out  8  byte to UART TX.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  UART TX accepts byte when valid & ready.
- busy_o  out  1  high in LATCH/SEND.
- done_o  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async, any state): state=IDLE, reg_idx=0, byte_cnt=0, shift_reg=0. rs_dbg_addr_o=0, tx_data_o=0, tx_valid_o=0, busy_o=0, done_o=0.
- rs_dbg_addr_o is driven directly from the reg_idx register (registered output, glitch-free).
- FSM states: IDLE, LATCH, SEND, DONE.
- IDLE:
  - start_i=1 -> reg_idx<=0, state<=LATCH.
  - start_i while not IDLE is ignored; it is neither queued nor a restart.
- LATCH:
  - shift_reg<=rs_dbg_data_i, byte_cnt<=0, state<=SEND.
  - One full cycle of address settle time is guaranteed because the address changed on the previous edge.
- SEND:
  - tx_valid_o=1.
  - tx_data_o = byte byte_cnt of shift_reg: LSB_FIRST=1 -> shift_reg[8k+7:8k]; LSB_FIRST=0 -> shift_reg[31-8k:24-8k].
  - tx_data_o must stay stable while valid & !ready; valid is never dropped before acceptance.
  - On accept with byte_cnt<3 -> byte_cnt++.
  - On accept with byte_cnt==3 and reg_idx<NUM_REGS-1 -> reg_idx++, state<=LATCH.
  - On accept with byte_cnt==3 and reg_idx==NUM_REGS-1 -> state<=DONE.
- DONE: done_o=1 for exactly one cycle, then state<=IDLE; reg_idx returns to 0.
- abort_i has priority over all transitions in LATCH/SEND/DONE: next state IDLE, tx_valid_o=0 next cycle, no done_o.
  - A byte accepted in the same cycle as abort counts as sent; no further bytes follow.
- x0 always reads as 0, so the first 4 bytes are 0x00.
- Snapshot semantics: each register is captured independently in its LATCH cycle. The dump is atomic across registers only if the core is halted.
  - A write landing on the negedge before LATCH is captured.
- Latency with tx_ready_i held 1 and start accepted at edge 0:
  - reg k: LATCH in cycle 1+5k, SEND in cycles 2+5k..5+5k.
  - NUM_REGS=32: 128 bytes, done_o in cycle 161, IDLE in cycle 162.
- Backpressure stretches SEND only; no byte loss or duplication.
- Counter widths: reg_idx 5 bits, byte_cnt 2 bits; no wrap beyond NUM_REGS-1.

Decomposition:
- Shared debug package holds:
  - dump_state_e enum {IDLE, LATCH, SEND, DONE};
  - BYTES_PER_REG=4;
  - DBG_ADDR_W=5.
- No sub-module is needed; the byte mux is inline. Total is a single module of roughly 150 lines.

Test Plan:
- Preload x1=0x11223344, x31=0xDEADBEEF, ready=1, LSB_FIRST=1, start pulse -> 128 bytes. Bytes 0-3=00 00 00 00, bytes 4-7=44 33 22 11, bytes 124-127=EF BE AD DE. done_o in cycle 161, busy_o low afterwards.
- LSB_FIRST=0, same preload -> bytes 4-7 = 11 22 33 44.
- Random tx_ready_i (~30% duty) -> identical 128-byte sequence. tx_data_o stable whenever valid & !ready; exactly one done_o pulse.
- start_i pulsed mid-dump (byte 40) -> ignored: stream continues unchanged, single done_o.
- abort_i at byte 50 -> tx_valid_o low next cycle, no done_o, busy_o=0. A new start restarts from x0 (first bytes 00 00 00 00).
- rst_n asserted mid-SEND with valid high -> outputs immediately 0, state IDLE. After release, start produces a full, correct dump.
